// File: rtl/sev_seg_pkg.sv
// Shared types and glyph constants for the seven-segment bus reader.
// Glyphs are active-low: a lit segment is a 0 bit. Bit order is bit0=a ... bit6=g.
// The event struct carries enough index bits for the largest supported digit count (8).
package sev_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0   = 7'h40;  // abcdef
  localparam seg_t GLYPH_1   = 7'h79;  // bc
  localparam seg_t GLYPH_2   = 7'h24;  // abdeg
  localparam seg_t GLYPH_3   = 7'h30;  // abcdg
  localparam seg_t GLYPH_4   = 7'h19;  // bcfg
  localparam seg_t GLYPH_5   = 7'h12;  // acdfg
  localparam seg_t GLYPH_6   = 7'h02;  // acdefg
  localparam seg_t GLYPH_7   = 7'h78;  // abc
  localparam seg_t GLYPH_8   = 7'h00;  // abcdefg
  localparam seg_t GLYPH_9   = 7'h18;  // abcfg
  localparam seg_t GLYPH_A   = 7'h08;  // abcefg
  localparam seg_t GLYPH_B   = 7'h03;  // cdefg
  localparam seg_t GLYPH_C   = 7'h46;  // adef
  localparam seg_t GLYPH_D   = 7'h21;  // bcdeg
  localparam seg_t GLYPH_E   = 7'h06;  // adefg
  localparam seg_t GLYPH_F   = 7'h0E;  // aefg
  localparam seg_t SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] val;
    logic       ok;
    logic       dp;
  } evt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sev_seg_enc.sv
// Segment pattern to hex value: inverse of the hex-to-segment decoder.
// Purely combinational, zero latency.
// No handshake; unrecognised patterns (including blank) give val=0, ok=0.
module sev_seg_enc
  import sev_seg_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] val,
  output logic       ok
);

  // Exact match against the sixteen legal glyphs; anything else is illegal.
  always_comb begin
    val = 4'h0;
    ok  = 1'b1;
    case (seg)
      GLYPH_0: val = 4'h0;
      GLYPH_1: val = 4'h1;
      GLYPH_2: val = 4'h2;
      GLYPH_3: val = 4'h3;
      GLYPH_4: val = 4'h4;
      GLYPH_5: val = 4'h5;
      GLYPH_6: val = 4'h6;
      GLYPH_7: val = 4'h7;
      GLYPH_8: val = 4'h8;
      GLYPH_9: val = 4'h9;
      GLYPH_A: val = 4'hA;
      GLYPH_B: val = 4'hB;
      GLYPH_C: val = 4'hC;
      GLYPH_D: val = 4'hD;
      GLYPH_E: val = 4'hE;
      GLYPH_F: val = 4'hF;
      default: begin
        val = 4'h0;
        ok  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sev_seg_reader.sv
// Passive monitor of a multiplexed active-low 7-seg bus: per-digit register file + change events.
// Latency: input stable from edge k shows on digit_* after edge k+SYNC_STAGES+STABLE_CYCLES.
// Backpressure: event register holds while !evt_ready; a new event arriving then is dropped and sets ovf.
module sev_seg_reader
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic                    dp_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic [NUM_DIGITS-1:0]   digit_dp,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [IDX_W-1:0]        evt_idx,
  output logic [3:0]              evt_val,
  output logic                    evt_ok,
  output logic                    evt_dp,
  output logic                    ovf,
  input  logic                    clr_ovf
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] BUS_IDLE = '1;

  logic [SW-1:0]         sync_q [SYNC_STAGES];
  logic [SW-1:0]         prev_q;
  logic [SW-1:0]         cur;
  logic [NUM_DIGITS-1:0] strobe;
  seg_t                  cur_seg;
  logic                  cur_dp;
  logic                  diff;
  logic                  one_hot;
  logic [IDX_W-1:0]      cur_idx;
  logic [CW-1:0]         cnt_q;
  rd_state_t             state_q, state_d;
  logic                  capture;
  logic [3:0]            enc_val;
  logic                  enc_ok;
  logic [3:0]            val_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] ok_q, dp_q, seen_q;
  logic                  new_evt;
  logic                  drop;
  evt_t                  evt_d, evt_q;

  // Bus synchronizer; resets to the idle bus so release never looks like a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
      prev_q <= BUS_IDLE;
    end else begin
      sync_q[0] <= {an_n, seg_n, dp_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur     = sync_q[SYNC_STAGES-1];
  assign strobe  = ~cur[SW-1:8];
  assign cur_seg = seg_t'(cur[7:1]);
  assign cur_dp  = cur[0];
  assign diff    = (cur != prev_q);
  assign one_hot = $onehot(strobe);

  // Position of the single active strobe (only meaningful when one_hot).
  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (strobe[i]) cur_idx = IDX_W'(i);
    end
  end

  // Run-length of identical synced samples, saturating at the capture threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (diff) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and capture strobe: one capture per stable one-hot run.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (one_hot) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (diff) begin
          state_d = one_hot ? ST_TRACK : ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (diff) state_d = one_hot ? ST_TRACK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sev_seg_enc u_enc (
    .seg (cur_seg),
    .val (enc_val),
    .ok  (enc_ok)
  );

  // Candidate event and whether it is new information for this digit.
  always_comb begin
    evt_d.idx = 3'(cur_idx);
    evt_d.val = enc_val;
    evt_d.ok  = enc_ok;
    evt_d.dp  = ~cur_dp;
    new_evt   = capture && (!seen_q[cur_idx] ||
                            ({val_q[cur_idx], ok_q[cur_idx], dp_q[cur_idx]} !=
                             {enc_val, enc_ok, ~cur_dp}));
    drop      = new_evt && evt_valid && !evt_ready;
  end

  // Per-digit register file; always updated on capture, even if the event is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) val_q[i] <= 4'h0;
      ok_q   <= '0;
      dp_q   <= '0;
      seen_q <= '0;
    end else if (capture) begin
      val_q[cur_idx]  <= enc_val;
      ok_q[cur_idx]   <= enc_ok;
      dp_q[cur_idx]   <= ~cur_dp;
      seen_q[cur_idx] <= 1'b1;
    end
  end

  // Single-entry event register; may reload on the same edge it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q     <= '0;
      evt_valid <= 1'b0;
    end else if (new_evt && (!evt_valid || evt_ready)) begin
      evt_q     <= evt_d;
      evt_valid <= 1'b1;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  // Sticky overflow; a drop on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  // Pack the register file onto the flat output buses.
  always_comb begin
    digit_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++) digit_val[4*i +: 4] = val_q[i];
  end

  assign digit_ok = ok_q;
  assign digit_dp = dp_q;
  assign evt_idx  = IDX_W'(evt_q.idx);
  assign evt_val  = evt_q.val;
  assign evt_ok   = evt_q.ok;
  assign evt_dp   = evt_q.dp;

endmodule

// File: tb/tb_sev_seg_reader.sv
// Bench for sev_seg_reader: behavioural model from glyph letters and sample run-lengths,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_sev_seg_reader;

  localparam int ND = 4;
  localparam int ST = 8;
  localparam int SY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic        dp_n = 1'b1;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] digit_val;
  logic [3:0]  digit_ok, digit_dp;
  logic        evt_valid, evt_ok, evt_dp, ovf;
  logic        evt_ready = 1'b1;
  logic        clr_ovf = 1'b0;
  logic [1:0]  evt_idx;
  logic [3:0]  evt_val;

  sev_seg_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST), .SYNC_STAGES(SY)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .digit_val(digit_val), .digit_ok(digit_ok), .digit_dp(digit_dp),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_val(evt_val), .evt_ok(evt_ok), .evt_dp(evt_dp),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  int dut_xfers = 0;
  logic [7:0] last_evt = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Glyphs written as lists of lit segments; the model derives bit patterns from them.
  string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph_pat(input int v);
    logic [6:0] p = 7'h7F;
    string s = glyph_str[v];
    for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 97] = 1'b0;
    return p;
  endfunction

  function automatic logic [4:0] decode(input logic [6:0] seg);
    for (int v = 0; v < 16; v++) if (glyph_pat(v) == seg) return {1'b1, 4'(v)};
    return 5'b0_0000;
  endfunction

  // Model state: what every output must be after the most recent edge.
  logic [11:0] m_last;
  int          m_rl;
  logic [11:0] hq [$];
  int          rq [$];
  logic [3:0]  m_val [ND];
  logic        m_ok [ND], m_dp [ND], m_seen [ND];
  logic        m_valid, m_ovf, m_eok, m_edp;
  logic [1:0]  m_eidx;
  logic [3:0]  m_eval;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 12'hFFF; m_rl = 0;
      hq.delete(); rq.delete();
      for (int i = 0; i < ND; i++) begin m_val[i] = 0; m_ok[i] = 0; m_dp[i] = 0; m_seen[i] = 0; end
      m_valid = 0; m_ovf = 0; m_eok = 0; m_edp = 0; m_eidx = 0; m_eval = 0;
    end else begin
      logic [11:0] s;
      logic        evt, xfer, drop;
      s = {an_n, seg_n, dp_n};
      m_rl = (s == m_last) ? m_rl + 1 : 1;
      m_last = s;
      hq.push_back(s); rq.push_back(m_rl);
      if (hq.size() > SY + 1) begin void'(hq.pop_front()); void'(rq.pop_front()); end
      xfer = m_valid && evt_ready;
      evt = 0; drop = 0;
      // A sample is captured once, when its run has lasted STABLE+1 samples, SYNC edges later.
      if (hq.size() == SY + 1 && rq[0] == ST + 1 && $countones(~hq[0][11:8]) == 1) begin
        int d; logic [4:0] dv; logic ndp;
        d = 0;
        for (int i = 0; i < ND; i++) if (!hq[0][8+i]) d = i;
        dv = decode(hq[0][7:1]);
        ndp = !hq[0][0];
        if (!m_seen[d] || m_val[d] != dv[3:0] || m_ok[d] != dv[4] || m_dp[d] != ndp) evt = 1;
        m_val[d] = dv[3:0]; m_ok[d] = dv[4]; m_dp[d] = ndp; m_seen[d] = 1;
        if (evt) begin
          if (!m_valid || evt_ready) begin
            m_valid = 1; m_eidx = 2'(d); m_eval = dv[3:0]; m_eok = dv[4]; m_edp = ndp;
          end else drop = 1;
        end
      end
      if (!evt && xfer) m_valid = 0;
      if (clr_ovf) m_ovf = 0;
      if (drop) m_ovf = 1;
    end
  end

  always @(posedge clk) begin
    edge_n++;
    if (rst_n && evt_valid && evt_ready) begin
      dut_xfers++;
      last_evt = {evt_idx, evt_val, evt_ok, evt_dp};
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [15:0] ev;
      logic [3:0]  eo, ed;
      for (int i = 0; i < ND; i++) begin ev[4*i +: 4] = m_val[i]; eo[i] = m_ok[i]; ed[i] = m_dp[i]; end
      check("cycle_outputs",
            {30'd0, digit_val, digit_ok, digit_dp, evt_valid, evt_idx, evt_val, evt_ok, evt_dp, ovf},
            {30'd0, ev, eo, ed, m_valid, m_eidx, m_eval, m_eok, m_edp, m_ovf});
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int cycles);
    an_n = an; seg_n = seg; dp_n = dp;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    drive(4'hF, 7'h7F, 1'b1, cycles);
  endtask

  initial begin
    int k;
    logic [6:0] scan_seg [4];
    scan_seg[0] = 7'h40; scan_seg[1] = 7'h00; scan_seg[2] = 7'h08; scan_seg[3] = 7'h7F;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("idle_no_event", {evt_valid, digit_ok, 16'(dut_xfers)}, 21'd0);

    // Stable "3" on digit 0: capture exactly SYNC+STABLE edges after the first stable edge.
    an_n = 4'b1110; seg_n = 7'h30; dp_n = 1'b1;
    k = edge_n + 1;
    for (int t = 0; t < 40 && !evt_valid; t++) @(negedge clk);
    check("evt_latency", 64'(edge_n - k), 64'd10);
    check("evt_fields_3", {evt_valid, evt_idx, evt_val, evt_ok, evt_dp}, {1'b1, 2'd0, 4'd3, 1'b1, 1'b0});
    drive(4'b1110, 7'h30, 1'b1, 10);
    idle(4);
    check("digit0_val", {digit_val[3:0], digit_ok[0]}, {4'd3, 1'b1});
    check("model_pin_3", {m_val[0], m_ok[0]}, {4'd3, 1'b1});
    check("one_event", 64'(dut_xfers), 64'd1);

    // Two full scans; only the first produces events.
    for (int rep = 0; rep < 2; rep++) begin
      for (int d = 0; d < 4; d++) drive(~(4'b0001 << d), scan_seg[d], 1'b1, 12);
      idle(12);
      check("scan_val", {digit_val, digit_ok}, {16'h0A80, 4'b0111});
      check("scan_events", 64'(dut_xfers), 64'd5);
    end

    // Short strobe and ghosted double strobe never capture.
    drive(4'b1101, 7'h79, 1'b1, 5);
    idle(15);
    drive(4'b1100, 7'h30, 1'b1, 20);
    idle(15);
    check("glitch_ghost", {digit_val, 16'(dut_xfers)}, {16'h0A80, 16'd5});

    // Backpressure: first event held, second dropped, ovf sticky until cleared.
    drive(4'b1110, 7'h30, 1'b1, 12);
    idle(4);
    evt_ready = 1'b0;
    drive(4'b1110, 7'h00, 1'b1, 12);
    idle(4);
    check("bp_held", {evt_valid, evt_idx, evt_val, evt_ok, evt_dp}, {1'b1, 2'd0, 4'd8, 1'b1, 1'b0});
    drive(4'b1101, 7'h24, 1'b1, 12);
    idle(4);
    check("bp_drop", {evt_valid, evt_idx, evt_val, ovf, digit_val[7:4]}, {1'b1, 2'd0, 4'd8, 1'b1, 4'd2});
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_clear", {31'd0, ovf}, 32'd0);
    evt_ready = 1'b1;
    idle(3);
    check("bp_events", 64'(dut_xfers), 64'd7);

    // Illegal pattern on digit 2.
    drive(4'b1011, 7'h7E, 1'b1, 12);
    idle(4);
    check("illegal_digit", {digit_ok[2], digit_val[11:8]}, {1'b0, 4'd0});
    check("illegal_evt", {last_evt, 16'(dut_xfers)}, {2'd2, 4'd0, 1'b0, 1'b0, 16'd8});

    // Randomized traffic; the per-cycle comparison does the checking.
    for (int it = 0; it < 300; it++) begin
      logic [3:0] an; logic [6:0] seg; int hold;
      an  = (($urandom % 8) == 0) ? 4'($urandom) : ~(4'b0001 << ($urandom % 4));
      seg = (($urandom % 5) == 0) ? 7'($urandom) : glyph_pat($urandom % 16);
      hold = $urandom_range(1, 14);
      an_n = an; seg_n = seg; dp_n = 1'($urandom);
      for (int c = 0; c < hold; c++) begin
        evt_ready = ($urandom % 4) != 0;
        clr_ovf   = ($urandom % 16) == 0;
        @(negedge clk);
      end
    end
    evt_ready = 1'b1; clr_ovf = 1'b0;
    idle(15);

    // Reset in the middle of a capture clears everything at once.
    drive(4'b1110, 7'h19, 1'b1, 5);
    rst_n = 1'b0;
    an_n = 4'hF; seg_n = 7'h7F;
    #1;
    check("reset_outputs",
          {30'd0, digit_val, digit_ok, digit_dp, evt_valid, evt_idx, evt_val, evt_ok, evt_dp, ovf}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("post_reset_quiet", {evt_valid, digit_ok, digit_val}, 21'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
